// File: rtl/jtframe_sdram64_pkg.sv
// Shared constants for the 64-bit burst SDRAM client.
package jtframe_sdram64_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_FILL = 2'd2;

  localparam int unsigned BURST_WORDS = 4;

endpackage

// File: rtl/jtframe_sdram64_cline.sv
// One cache line: valid/tag, four 16-bit words, tag compare and word select.
module jtframe_sdram64_cline
  import jtframe_sdram64_pkg::*;
#(
  parameter int AW = 22
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          we,
  input  logic [1:0]    waddr,
  input  logic [15:0]   wdata,
  input  logic          set_valid,
  input  logic [AW-3:0] set_tag,
  input  logic [AW-3:0] cmp_tag,
  input  logic [1:0]    rsel,
  output logic          hit,
  output logic [15:0]   rdata
);

  logic          valid;
  logic [AW-3:0] tag;
  logic [15:0]   data [BURST_WORDS];

  // Line ownership: invalidation wins over a completing fill.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      tag   <= '0;
    end else if (clr) begin
      valid <= 1'b0;
    end else if (set_valid) begin
      valid <= 1'b1;
      tag   <= set_tag;
    end
  end

  // Word storage, written one word per data strobe.
  always_ff @(posedge clk) begin
    if (we) data[waddr] <= wdata;
  end

  // Tag compare and word select.
  always_comb begin
    hit   = valid && (tag == cmp_tag);
    rdata = data[rsel];
  end

endmodule

// File: rtl/jtframe_sdram64_client.sv
// Client requester: turns held read requests into burst-of-4 line fills
// into a two-line cache.
module jtframe_sdram64_client
  import jtframe_sdram64_pkg::*;
#(
  parameter int AW   = 22,
  parameter int BLEN = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cs,
  input  logic [AW-1:0] addr,
  input  logic          clr,
  output logic          data_ok,
  output logic [15:0]   dout,
  output logic          sdram_rd,
  output logic [AW-1:0] sdram_addr,
  input  logic          sdram_ack,
  input  logic          sdram_dst,
  input  logic          sdram_dok,
  input  logic          sdram_rdy,
  input  logic [15:0]   sdram_din
);

  logic [1:0]  state;
  logic        lru;
  logic        fill_line;
  logic        clr_seen;
  logic [1:0]  wcnt;
  logic [1:0]  line_hit;
  logic [1:0]  line_we;
  logic [1:0]  line_set;
  logic [15:0] line_data [2];
  logic        any_hit;
  logic        hit_line;
  logic        last_word;
  logic        unused_dst;

  // Data-start strobe carries no information this client needs.
  assign unused_dst = sdram_dst;

  // Hit resolution (line 0 wins a double match) and fill write enables.
  always_comb begin
    any_hit   = cs && (|line_hit);
    hit_line  = ~line_hit[0];
    last_word = (state == ST_FILL) && sdram_dok && (wcnt == 2'(BLEN-1));
    line_we   = '0;
    line_set  = '0;
    for (int unsigned i = 0; i < 2; i++) begin
      line_we[i]  = (state == ST_FILL) && sdram_dok && (fill_line == 1'(i));
      line_set[i] = last_word && (fill_line == 1'(i)) && !clr_seen && !clr;
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_line
    jtframe_sdram64_cline #(.AW(AW)) u_line (
      .clk       (clk),
      .rst       (rst),
      .clr       (clr),
      .we        (line_we[g]),
      .waddr     (wcnt),
      .wdata     (sdram_din),
      .set_valid (line_set[g]),
      .set_tag   (sdram_addr[AW-1:2]),
      .cmp_tag   (addr[AW-1:2]),
      .rsel      (addr[1:0]),
      .hit       (line_hit[g]),
      .rdata     (line_data[g])
    );
  end

  // Request FSM, LRU tracking and registered read response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      data_ok    <= 1'b0;
      dout       <= '0;
      sdram_rd   <= 1'b0;
      sdram_addr <= '0;
      lru        <= 1'b0;
      fill_line  <= 1'b0;
      wcnt       <= '0;
      clr_seen   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          data_ok <= any_hit;
          if (any_hit) begin
            dout <= line_data[hit_line];
            lru  <= ~hit_line;
          end else if (cs && !clr) begin
            sdram_addr <= {addr[AW-1:2], 2'b00};
            fill_line  <= lru;
            sdram_rd   <= 1'b1;
            wcnt       <= '0;
            clr_seen   <= 1'b0;
            state      <= ST_REQ;
          end
        end
        ST_REQ: begin
          data_ok <= 1'b0;
          if (clr) clr_seen <= 1'b1;
          if (sdram_ack) begin
            sdram_rd <= 1'b0;
            state    <= ST_FILL;
          end
        end
        ST_FILL: begin
          data_ok <= 1'b0;
          if (clr) clr_seen <= 1'b1;
          if (sdram_dok) begin
            wcnt <= wcnt + 2'd1;
            if (last_word) state <= ST_IDLE;
          end else if (sdram_rdy) begin
            // Burst ended short: abandon the line without marking it valid.
            wcnt  <= '0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jtframe_sdram64_client.sv
// Randomised bench for jtframe_sdram64_client with a transaction-level model.
module tb_jtframe_sdram64_client;

  localparam int AW = 22;

  logic          clk = 1'b0;
  logic          rst, cs, clr;
  logic [AW-1:0] addr;
  logic          data_ok;
  logic [15:0]   dout;
  logic          sdram_rd;
  logic [AW-1:0] sdram_addr;
  logic          sdram_ack, sdram_dst, sdram_dok, sdram_rdy;
  logic [15:0]   sdram_din;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  jtframe_sdram64_client #(.AW(AW), .BLEN(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .cs         (cs),
    .addr       (addr),
    .clr        (clr),
    .data_ok    (data_ok),
    .dout       (dout),
    .sdram_rd   (sdram_rd),
    .sdram_addr (sdram_addr),
    .sdram_ack  (sdram_ack),
    .sdram_dst  (sdram_dst),
    .sdram_dok  (sdram_dok),
    .sdram_rdy  (sdram_rdy),
    .sdram_din  (sdram_din)
  );

  // Backing memory content: word k of line L is (k+1)*0x1111 ^ (L-1)*0x0137,
  // so the line at 0x000004 holds 0x1111, 0x2222, 0x3333, 0x4444.
  function automatic logic [15:0] mem(input logic [AW-1:0] a);
    logic [15:0] w, l;
    w = 16'(({14'd0, a[1:0]} + 16'd1) * 16'h1111);
    l = 16'(a[AW-1:2]) - 16'd1;
    return w ^ 16'(l * 16'h0137);
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- transaction-level reference model ----------------
  // phase 0: serving hits, 1: request outstanding, 2: collecting words
  logic            m_v [2];
  logic [AW-3:0]   m_tag [2];
  int              m_lru, m_phase, m_fline, m_words;
  bit              m_cseen;
  logic [AW-3:0]   m_ftag;
  logic            exp_ok, exp_rd;
  logic [15:0]     exp_dout;
  logic [AW-1:0]   exp_addr;
  bit              h0, h1;

  always @(posedge clk) begin
    if (rst) begin
      m_v[0] = 1'b0; m_v[1] = 1'b0;
      m_lru = 0; m_phase = 0; m_words = 0; m_cseen = 1'b0;
      exp_ok = 1'b0; exp_rd = 1'b0; exp_dout = '0; exp_addr = '0;
    end else begin
      if (m_phase == 0) begin
        h0 = m_v[0] && (m_tag[0] == addr[AW-1:2]);
        h1 = m_v[1] && (m_tag[1] == addr[AW-1:2]);
        exp_ok = cs && (h0 || h1);
        if (exp_ok) begin
          exp_dout = mem(addr);
          m_lru = h0 ? 1 : 0;
        end else if (cs && !clr) begin
          m_phase = 1; exp_rd = 1'b1;
          m_ftag = addr[AW-1:2];
          exp_addr = {addr[AW-1:2], 2'b00};
          m_fline = m_lru; m_words = 0; m_cseen = 1'b0;
        end
      end else begin
        exp_ok = 1'b0;
        if (clr) m_cseen = 1'b1;
        if (m_phase == 1) begin
          if (sdram_ack) begin exp_rd = 1'b0; m_phase = 2; end
        end else if (sdram_dok) begin
          m_words++;
          if (m_words == 4) begin
            m_phase = 0;
            if (!m_cseen) begin m_v[m_fline] = 1'b1; m_tag[m_fline] = m_ftag; end
          end
        end else if (sdram_rdy) begin
          m_phase = 0;
        end
      end
      if (clr) begin m_v[0] = 1'b0; m_v[1] = 1'b0; end
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("data_ok", {31'd0, data_ok}, {31'd0, exp_ok});
      cmp("dout", {16'd0, dout}, {16'd0, exp_dout});
      cmp("sdram_rd", {31'd0, sdram_rd}, {31'd0, exp_rd});
      cmp("sdram_addr", 32'(sdram_addr), 32'(exp_addr));
    end
  end

  // ---------------- controller responder ----------------
  int            gmin = 2, gmax = 2;
  bit            resp_busy = 1'b0;
  int            resp_words = 0;
  logic [AW-1:0] base;

  task automatic rstep();
    @(posedge clk);
    #2;
  endtask

  initial begin
    sdram_ack = 1'b0; sdram_dst = 1'b0; sdram_dok = 1'b0; sdram_rdy = 1'b0; sdram_din = '0;
    forever begin
      rstep();
      if (sdram_rd === 1'b1) begin
        resp_busy = 1'b1; resp_words = 0; base = sdram_addr;
        repeat ($urandom_range(0, 2)) rstep();
        sdram_ack = 1'b1; rstep(); sdram_ack = 1'b0;
        sdram_dst = 1'b1; rstep(); sdram_dst = 1'b0;
        for (int k = 0; k < 4; k++) begin
          repeat ($urandom_range(gmin, gmax)) rstep();
          sdram_dok = 1'b1; sdram_rdy = (k == 3);
          sdram_din = mem(AW'(base + AW'(k)));
          rstep();
          sdram_dok = 1'b0; sdram_rdy = 1'b0; sdram_din = $urandom();
          resp_words = k + 1;
        end
        resp_busy = 1'b0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_ok(input int lim, output bit got);
    got = 1'b0;
    for (int i = 0; i < lim; i++) begin
      if (data_ok) begin got = 1'b1; break; end
      step();
    end
  endtask

  task automatic wait_words(input int n, output bit got);
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (resp_busy && resp_words == n) begin got = 1'b1; break; end
      step();
    end
  endtask

  task automatic wait_quiet(output bit got);
    got = 1'b0;
    for (int i = 0; i < 150; i++) begin
      if (!resp_busy && !sdram_rd) begin got = 1'b1; break; end
      step();
    end
    step(); step();
  endtask

  task automatic read_line(input logic [AW-1:0] a);
    bit got;
    addr = a; cs = 1'b1;
    step();
    wait_ok(120, got);
    cmp("read_ok_timeout", {31'd0, got}, 32'd1);
    cs = 1'b0;
    step();
  endtask

  initial begin
    bit got;
    int mode;
    logic [AW-1:0] a;
    rst = 1'b1; cs = 1'b1; addr = '0; clr = 1'b0;
    step();
    chk_en = 1'b1;
    cmp("rst_data_ok", {31'd0, data_ok}, 32'd0);
    cmp("rst_dout", {16'd0, dout}, 32'd0);
    cmp("rst_rd", {31'd0, sdram_rd}, 32'd0);
    step();
    cmp("rst_rd_hold", {31'd0, sdram_rd}, 32'd0);
    cmp("rst_addr", 32'(sdram_addr), 32'd0);
    rst = 1'b0; cs = 1'b0;
    step();

    // cold miss
    addr = 22'h000005; cs = 1'b1;
    step();
    cmp("cold_rd", {31'd0, sdram_rd}, 32'd1);
    cmp("cold_addr", 32'(sdram_addr), 32'h4);
    step();
    wait_ok(60, got);
    cmp("cold_ok", {31'd0, got}, 32'd1);
    cmp("cold_dout", {16'd0, dout}, 32'h2222);

    // hit on same line
    addr = 22'h000007;
    step();
    cmp("hit_ok", {31'd0, data_ok}, 32'd1);
    cmp("hit_dout", {16'd0, dout}, 32'h4444);
    cmp("hit_rd", {31'd0, sdram_rd}, 32'd0);
    cs = 1'b0;
    step();

    // LRU eviction
    read_line(22'h000010);
    addr = 22'h000004; cs = 1'b1;
    step();
    cmp("lru_hit4", {31'd0, data_ok}, 32'd1);
    cs = 1'b0; step();
    read_line(22'h000020);
    addr = 22'h000004; cs = 1'b1;
    step();
    cmp("lru_keep4_ok", {31'd0, data_ok}, 32'd1);
    cmp("lru_keep4_dout", {16'd0, dout}, 32'h1111);
    cmp("lru_keep4_rd", {31'd0, sdram_rd}, 32'd0);
    cs = 1'b0; step();
    addr = 22'h000010; cs = 1'b1;
    step();
    cmp("lru_evicted_rd", {31'd0, sdram_rd}, 32'd1);
    cs = 1'b0;
    wait_quiet(got);

    // clr during fill
    addr = 22'h000030; cs = 1'b1;
    step();
    wait_words(2, got);
    cmp("clr_words2_timeout", {31'd0, got}, 32'd1);
    clr = 1'b1; step(); clr = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (sdram_rd) begin got = 1'b1; break; end
      step();
    end
    cmp("clr_rd_again", {31'd0, got}, 32'd1);
    cmp("clr_words_consumed", 32'(resp_words), 32'd4);
    cmp("clr_same_addr", 32'(sdram_addr), 32'h30);
    step();
    wait_ok(60, got);
    cmp("clr_refill_ok", {31'd0, got}, 32'd1);
    cs = 1'b0;
    wait_quiet(got);

    // reset mid-fill with stray strobes afterwards
    addr = 22'h000044; cs = 1'b1;
    step();
    wait_words(1, got);
    cmp("rstfill_words1_timeout", {31'd0, got}, 32'd1);
    rst = 1'b1; cs = 1'b0;
    step(); step();
    rst = 1'b0;
    wait_quiet(got);
    cmp("rstfill_quiet", {31'd0, got}, 32'd1);
    cmp("rstfill_no_ok", {31'd0, data_ok}, 32'd0);
    addr = 22'h000030; cs = 1'b1;
    step();
    cmp("rstfill_fresh_rd", {31'd0, sdram_rd}, 32'd1);
    cmp("rstfill_fresh_no_ok", {31'd0, data_ok}, 32'd0);
    step();
    wait_ok(60, got);
    cmp("rstfill_refill_ok", {31'd0, got}, 32'd1);
    cs = 1'b0;
    step();

    // randomised traffic
    gmin = 0; gmax = 2;
    for (int it = 0; it < 400; it++) begin
      a = AW'($urandom_range(0, 63));
      if ($urandom_range(0, 3) == 0) a[AW-1:16] = 6'($urandom());
      addr = a; cs = 1'b1;
      clr = ($urandom_range(0, 15) == 0);
      step();
      clr = 1'b0;
      mode = int'($urandom_range(0, 7));
      if (mode == 0) begin
        repeat ($urandom_range(0, 3)) step();
        cs = 1'b0;
        wait_quiet(got);
        cmp("rand_quiet_timeout", {31'd0, got}, 32'd1);
      end else begin
        if (mode == 2) begin
          repeat ($urandom_range(0, 6)) step();
          clr = 1'b1; step(); clr = 1'b0;
        end
        wait_ok(150, got);
        cmp("rand_ok_timeout", {31'd0, got}, 32'd1);
        if (mode == 1) begin
          addr = {a[AW-1:2], 2'($urandom())};
          step();
        end
        if (mode[0]) begin
          cs = 1'b0;
          step();
        end
      end
    end
    cs = 1'b0;
    step(); step();
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/jtframe_sdram64_client.md
# jtframe_sdram64_client

Client-side requester for one bank port of the 64-bit burst SDRAM controller. It turns a slow, address-held game/CPU read request into burst-of-4 (64-bit) line fills. Each fill is a single `rd` request to the controller. The returned 16-bit words are captured on the controller's data strobes and held in a two-line cache. One instance sits between each ROM consumer and `rd[n]/ack[n]/dst[n]/dok[n]/rdy[n]/dout` of the controller.

## Interface
Parameters:
- `AW`, 22 — SDRAM word-address width; matches the controller.
- `BLEN`, 4 — words per burst. Fixed to 4 (64-bit burst); other values are illegal.

Ports:
- `clk`  in  1  system clock; everything is on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `cs`  in  1  client read request, held high with `addr` stable until `data_ok`.
- `addr`  in  AW  client 16-bit word address.
- `clr`  in  1  invalidate both cache lines (after download/prog_en).
- `data_ok`  out  1  `dout` is valid for the current `addr`.
- `dout`  out  16  read data.
- `sdram_rd`  out  1  read request to the controller bank.
- `sdram_addr`  out  AW  burst start address, `{addr[AW-1:2],2'b00}`.
- `sdram_ack`  in  1  controller accepted the request.
- `sdram_dst`  in  1  data about to start.
- `sdram_dok`  in  1  `sdram_din` holds a valid word this cycle.
- `sdram_rdy`  in  1  burst complete.
- `sdram_din`  in  16  shared controller data bus (`dout` of the controller).

## Operation
- Cache: 2 lines. Each line has `valid`, `tag = addr[AW-1:2]`, and `data[3:0][15:0]`. One `lru` bit points at the victim line.
- Hit: `cs & valid[i] & tag[i]==addr[AW-1:2]`. If both lines match, line 0 wins.
- FSM states:
  - `IDLE`:
    - With `cs` and a hit: register `dout = data[i][addr[1:0]]`, set `data_ok`, set `lru` to the other line.
    - With `cs`, a miss and `!clr`: latch the burst address and the victim `lru` into `fill_line`, then go to `REQ`.
  - `REQ`: `sdram_rd=1`. When `sdram_ack` is sampled high, go to `FILL`.
  - `FILL`:
    - Each `sdram_dok` cycle writes `sdram_din` to `data[fill_line][wcnt]` and increments the 2-bit `wcnt`.
    - On the 4th word: set `valid[fill_line]` and `tag`, and return to `IDLE`. The hit then resolves normally.
- `sdram_dst` is informational only. `sdram_rdy` arriving before 4 words are captured is a protocol error; `valid` is not set and the FSM returns to `IDLE`.
- `clr` clears both `valid` bits in any state. If `clr` is seen during `REQ`/`FILL`, the fill completes on the bus but `valid` is not set on completion.
- `cs` low in `IDLE` drops `data_ok` next cycle. `cs` dropping during `REQ`/`FILL` does not abort the fill.
- `addr` change with `cs` high: `data_ok` is recomputed from the new address (registered) and is never held over from the old address.

## Timing
- Reset values: `data_ok=0`, `dout=0`, `sdram_rd=0`, `sdram_addr=0`, `valid=2'b00`, `lru=0`, `wcnt=0`, state `IDLE`.
- Hit latency: `cs`/`addr` sampled in cycle N gives `data_ok`/`dout` in cycle N+1.
- Miss:
  - `sdram_rd` rises in cycle N+1.
  - `sdram_rd` falls the cycle after `sdram_ack` is sampled.
  - Line is valid the cycle after the 4th `sdram_dok`.
  - `data_ok` follows one cycle after that.
- `sdram_addr` is stable from `REQ` entry until `FILL` exit.
- `rst` mid-`REQ`/`FILL`: everything returns to reset values next cycle. `sdram_dok` arriving while in `IDLE` is ignored.

## Structure
- Package `jtframe_sdram64_pkg` holds:
  - state encodings `ST_IDLE`, `ST_REQ`, `ST_FILL`;
  - `BURST_WORDS=4`.
- Sub-module `jtframe_sdram64_cline` (one per line): holds valid/tag/data storage, the word-write port, the tag compare, and the word-select read. The top holds the FSM, LRU and handshake.

## Test plan
- Reset:
  - Stimulus: assert `rst` 2 cycles with `cs=1`.
  - Required: all outputs are 0; no `sdram_rd` until `rst` falls.
- Cold miss:
  - Stimulus: `addr=0x000005`, `cs=1`.
  - Required: `sdram_rd=1` with `sdram_addr=0x000004`. After `ack`, send dok words 0x1111, 0x2222, 0x3333, 0x4444. `data_ok=1` with `dout=0x2222`.
- Hit:
  - Stimulus: after the cold miss, `addr=0x000007`.
  - Required: `data_ok` 1 cycle later with `dout=0x4444`; `sdram_rd` stays 0.
- LRU eviction:
  - Stimulus: fill line for 0x000010, then read 0x000004 (hit), then miss on 0x000020.
  - Required: the 0x000010 line is replaced. A later read of 0x000004 hits with no request.
- `clr` during `FILL`:
  - Stimulus: pulse `clr` after the 2nd dok word.
  - Required: 4 words are still consumed, `valid` stays 0, and `sdram_rd` re-asserts for the same address.
- Reset mid-`FILL`:
  - Stimulus: assert `rst` after 1 dok word; 3 stray dok pulses follow.
  - Required: no `data_ok`, and the cache is empty. The next `cs` issues a fresh `sdram_rd`.
